// File: rtl/sar_pkg.sv
// Shared definitions for the signed successive-approximation search block.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_e;

  // Widest value the offset-binary helper handles.
  localparam int SAR_MAX_W = 64;

  // Flip the sign bit of an n-bit two's-complement value to move between the
  // signed and offset-binary views. The conversion works in both directions.
  // Only the low n bits of the return value are meaningful.
  function automatic logic [SAR_MAX_W-1:0] to_offset(input logic [SAR_MAX_W-1:0] v,
                                                     input int n);
    return v ^ (64'd1 << (n - 1));
  endfunction

endpackage

// File: rtl/comparator_lt.sv
// Signed less-than comparator that sits outside the search block.
module comparator_lt #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic                out
);

  assign out = (a < b);

endmodule

// File: rtl/signed_sar_search.sv
// Bit-serial search that recovers a signed target by driving trial values
// to an external comparator. The search walks from MSB to LSB in offset binary,
// so a plain unsigned bit-by-bit search orders signed values correctly.
// N must lie in the range 2..64, which is the range the package helper supports.
module signed_sar_search
  import sar_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                lt,
  output logic signed [N-1:0] probe,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] result
);

  localparam logic [N-1:0] SIGN_BIT = {1'b1, {(N-1){1'b0}}};

  sar_state_e   state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] trial_q, trial_d;
  logic [N-1:0] probe_q, probe_d;
  logic [N-1:0] result_q, result_d;
  logic [N-1:0] resolved;

  // Next-state logic: load on start, resolve one bit per cycle, and publish the result on the last bit.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    trial_d  = trial_q;
    probe_d  = probe_q;
    result_d = result_q;
    resolved = trial_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          ptr_d   = SIGN_BIT;
          trial_d = SIGN_BIT;
          probe_d = '0;
        end
      end
      SEARCH: begin
        resolved = lt ? (trial_q & ~ptr_q) : trial_q;
        ptr_d    = ptr_q >> 1;
        trial_d  = resolved | (ptr_q >> 1);
        probe_d  = N'(to_offset(64'(trial_d), N));
        if (ptr_q[0]) begin
          state_d  = DONE;
          result_d = N'(to_offset(64'(resolved), N));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; probe is registered so it has no path from lt or start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      trial_q  <= '0;
      probe_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      trial_q  <= trial_d;
      probe_q  <= probe_d;
      result_q <= result_d;
    end
  end

  assign probe  = probe_q;
  assign result = result_q;
  assign busy   = (state_q == SEARCH);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_signed_sar_search.sv
// Randomised self-checking bench for signed_sar_search with the comparator in the loop.
module tb_signed_sar_search;
  import sar_pkg::*;

  localparam int N = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] target = '0;
  logic                lt;
  logic signed [N-1:0] probe;
  logic signed [N-1:0] result;
  logic                busy;
  logic                done;

  int pass_count  = 0;
  int check_count = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  signed_sar_search #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .lt     (lt),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  comparator_lt #(.N(N)) cmp (
    .a   (target),
    .b   (probe),
    .out (lt)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference model: an interval binary search over the signed range.
  // Starting at the lowest value, each step asks whether target >= base+step.
  function automatic int modelProbe(input int tgt, input int k);
    int base = -(1 << (N - 1));
    int step = 1 << (N - 1);
    for (int i = 0; i < k; i++) begin
      if (tgt >= base + step) base += step;
      step /= 2;
    end
    return base + step;
  endfunction

  function automatic int modelResult(input int tgt);
    int base = -(1 << (N - 1));
    int step = 1 << (N - 1);
    for (int i = 0; i < N; i++) begin
      if (tgt >= base + step) base += step;
      step /= 2;
    end
    return base;
  endfunction

  task automatic applyStimulus(input int tgt, input bit full_check);
    int  edges = 0;
    int  n_probe = 0;
    bit  seen = 1'b0;
    logic [63:0] off;
    target = N'(tgt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    for (int k = 0; k < 4 * N; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        if (full_check)
          checkOutput($sformatf("probe[%0d] t=%0d", n_probe, tgt), int'(probe), modelProbe(tgt, n_probe));
        n_probe++;
      end
      @(posedge clk);
      edges++;
    end
    checkOutput($sformatf("done seen t=%0d", tgt), int'(seen), 1);
    if (seen) begin
      checkOutput($sformatf("result t=%0d", tgt), int'(result), modelResult(tgt));
      if (full_check) begin
        checkOutput($sformatf("edges to done t=%0d", tgt), edges, N + 1);
        checkOutput($sformatf("probe count t=%0d", tgt), n_probe, N);
        off = to_offset(64'(result), N);
        checkOutput($sformatf("offset result t=%0d", tgt), int'(off[N-1:0]), tgt + (1 << (N - 1)));
        @(negedge clk);
        checkOutput($sformatf("done width t=%0d", tgt), int'(done), 0);
        checkOutput($sformatf("idle busy t=%0d", tgt), int'(busy), 0);
      end
    end
  endtask

  initial begin
    int tgt;
    int busy_cyc;
    int done_cnt;
    bit seen;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset probe", int'(probe), 0);
    checkOutput("reset result", int'(result), 0);
    rst = 1'b1;

    // Directed example: target 5 gives probes 0,64,32,16,8,4,6,5
    checkOutput("model probe[5]", modelProbe(5, 5), 4);
    applyStimulus(5, 1'b1);

    // In IDLE probe holds and lt is ignored even when the target changes
    target = -8'sd100;
    repeat (3) @(negedge clk);
    checkOutput("idle probe hold", int'(probe), 5);
    checkOutput("idle result hold", int'(result), 5);
    checkOutput("idle busy", int'(busy), 0);

    // Extremes, zero and minus one
    applyStimulus(-128, 1'b1);
    applyStimulus(127, 1'b1);
    applyStimulus(0, 1'b1);
    applyStimulus(-1, 1'b1);

    // start held high: single done, one IDLE cycle, then the next search begins
    target = -8'sd37;
    @(negedge clk);
    start = 1'b1;
    busy_cyc = 0;
    done_cnt = 0;
    for (int k = 0; k < 4 * N; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        break;
      end
    end
    checkOutput("held busy cycles", busy_cyc, N);
    checkOutput("held done count", done_cnt, 1);
    checkOutput("held result", int'(result), -37);
    @(negedge clk);
    checkOutput("held after done done", int'(done), 0);
    checkOutput("held after done busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("held restart busy", int'(busy), 1);
    checkOutput("held restart probe", int'(probe), 0);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 * N; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("held second done", int'(seen), 1);
    checkOutput("held second result", int'(result), -37);

    // Reset during the third SEARCH cycle aborts the search
    target = 8'sd90;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort result", int'(result), 0);
    checkOutput("abort probe", int'(probe), 0);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("abort no done", int'(seen), 0);
    checkOutput("abort result held", int'(result), 0);
    applyStimulus(90, 1'b1);

    // Reset wins over start on the same edge
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("priority busy", int'(busy), 0);
    checkOutput("priority result", int'(result), 0);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("priority idle", int'(busy), 0);

    // Random targets with full probe-sequence checks
    for (int i = 0; i < 30; i++) begin
      tgt = int'($urandom_range(255, 0)) - 128;
      applyStimulus(tgt, 1'b1);
    end

    // Exhaustive sweep of every 8-bit target
    for (int t = -128; t < 128; t++) begin
      applyStimulus(t, 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
